uart_fifo: RTL and testbench
============================

UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, entries per TX and RX FIFO, power of two, 2..16.
REQ-003 SHALL have parameter DIV_W, default 12, width of baud_div.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port baud_div  in  DIV_W  bit period minus one, in clk cycles.
REQ-007 SHALL have port parity_en  in  1  append/check parity bit.
REQ-008 SHALL have port parity_odd  in  1  1=odd, 0=even parity.
REQ-009 SHALL have port two_stop  in  1  TX sends two stop bits.
REQ-010 SHALL have port tx_data  in  DATA_BITS  byte to enqueue.
REQ-011 SHALL have port tx_write  in  1  enqueue strobe, one entry per high cycle.
REQ-012 SHALL have port tx_full  out  1  TX FIFO full.
REQ-013 SHALL have port tx_busy  out  1  frame in progress or TX FIFO non-empty.
REQ-014 SHALL have port tx  out  1  serial out, idle high.
REQ-015 SHALL have port cts  in  1  peer ready; TX starts a new frame only while high.
REQ-016 SHALL have port rx  in  1  serial in, asynchronous.
REQ-017 SHALL have port rx_data  out  DATA_BITS  RX FIFO head (show-ahead).
REQ-018 SHALL have port rx_read  in  1  dequeue strobe.
REQ-019 SHALL have port rx_empty  out  1  RX FIFO empty.
REQ-020 SHALL have port rx_err  out  3  sticky {overrun, frame, parity}; cleared by rx_read or reset.
REQ-021 SHALL have port rts  out  1  high while RX FIFO has at least one free entry.

Function
REQ-022 Bit period SHALL be exactly baud_div+1 clk cycles; TX and RX have independent counters.
REQ-023 Frame SHALL be start(0), DATA_BITS LSB-first, optional parity, stop(1) x (two_stop?2:1).
REQ-024 Parity bit SHALL equal XOR of data bits, inverted when parity_odd.
REQ-025 TX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; PARITY skipped when parity_en=0.
REQ-026 In IDLE with FIFO non-empty and cts=1, TX SHALL pop the head and drive start bit on the next cycle.
REQ-027 cts falling mid-frame SHALL NOT abort the frame; only the next start is held.
REQ-028 tx_write while tx_full SHALL be ignored; simultaneous write and pop when full SHALL be accepted.
REQ-029 rx SHALL pass a two-flop synchroniser before any use.
REQ-030 RX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; frames always checked with one stop bit.
REQ-031 RX SHALL leave IDLE on a synchronised 1->0 transition, sample at floor(baud_div/2) cycles later, and return to IDLE without enqueue if that sample is 1 (false start).
REQ-032 Subsequent bits SHALL be sampled every baud_div+1 cycles after the start-bit centre.
REQ-033 Stop sample 0 SHALL set frame error and discard the byte; RX then waits for line high before IDLE.
REQ-034 Parity mismatch SHALL set parity error; the byte is still enqueued.
REQ-035 A valid byte arriving with RX FIFO full SHALL be dropped and set overrun error.
REQ-036 rx_read while rx_empty SHALL be ignored; simultaneous read and enqueue SHALL both succeed.
REQ-037 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits with wrap bit distinguishing full from empty.
REQ-038 baud_div and mode inputs SHALL be held stable by the user while a frame is active; behaviour otherwise undefined.

Reset
REQ-039 While rst=1: both FSMs IDLE, FIFOs empty, counters 0, tx=1, tx_full=0, tx_busy=0, rx_empty=1, rx_err=0, rts=1, rx_data=0.
REQ-040 Reset mid-frame SHALL abort immediately; tx=1 the cycle after rst sampled high, queued data lost.

Verification
REQ-041 DATA_BITS=8, baud_div=3, no parity, write 0xA5 -> tx 0,1,0,1,0,0,1,0,1,1 each 4 cycles; tx_busy low after stop.
REQ-042 Loop tx->rx, parity_en=1 odd, two_stop=1, send 0x00,0xFF,0x3C -> rx_data same order, rx_err=000.
REQ-043 FIFO_DEPTH=4, cts=0, write 5 bytes -> tx_full after 4th, 5th dropped; raise cts -> exactly 4 frames sent.
REQ-044 Inject 0x55 with stop bit 0 -> rx_empty stays 1, rx_err=010; 2-cycle rx low glitch -> no frame, no error.
REQ-045 Receive 5 frames without rx_read, FIFO_DEPTH=4 -> rts low after 4th, rx_err=100, first 4 bytes intact.
REQ-046 Assert rst mid-TX-data-bit -> tx=1 next cycle, tx_busy=0, subsequent write transmits cleanly.

Source files
------------

// File: rtl/uart_fifo.sv
// UART with independent TX/RX FIFOs, programmable bit period, optional parity,
// one or two TX stop bits and RTS/CTS flow control.
module uart_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_write,
  output logic                 tx_full,
  output logic                 tx_busy,
  output logic                 tx,
  input  logic                 cts,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_read,
  output logic                 rx_empty,
  output logic [2:0]           rx_err,
  output logic                 rts
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  logic [DATA_BITS-1:0] txMem_q [FIFO_DEPTH];
  logic [AW:0]          txWr_q, txWr_d, txRd_q, txRd_d;
  logic                 txEmpty, txFull, txPop, txPush;
  logic [DATA_BITS-1:0] txHead;

  state_e               txState_q;
  logic [DIV_W-1:0]     txCnt_q;
  logic [BW-1:0]        txBit_q;
  logic [DATA_BITS-1:0] txShift_q;
  logic                 txPar_q, txStop2_q, tx_q;
  logic                 txTick;

  assign txEmpty = (txWr_q == txRd_q);
  assign txFull  = (txWr_q[AW] != txRd_q[AW]) && (txWr_q[AW-1:0] == txRd_q[AW-1:0]);
  assign txPop   = (txState_q == IDLE) && !txEmpty && cts;
  // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign txPush  = tx_write && (!txFull || txPop);
  assign txHead  = txMem_q[txRd_q[AW-1:0]];
  assign txTick  = (txCnt_q == baud_div);

  always_comb begin
    txWr_d = txWr_q + {{AW{1'b0}}, txPush};
    txRd_d = txRd_q + {{AW{1'b0}}, txPop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txWr_q <= '0;
      txRd_q <= '0;
    end else begin
      txWr_q <= txWr_d;
      txRd_q <= txRd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (txPush) txMem_q[txWr_q[AW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txState_q <= IDLE;
      txCnt_q   <= '0;
      txBit_q   <= '0;
      txShift_q <= '0;
      txPar_q   <= 1'b0;
      txStop2_q <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      case (txState_q)
        IDLE: begin
          tx_q    <= 1'b1;
          txCnt_q <= '0;
          if (txPop) begin
            txShift_q <= txHead;
            txPar_q   <= ^txHead ^ parity_odd;
            tx_q      <= 1'b0;
            txState_q <= START;
          end
        end
        default: begin
          if (!txTick) begin
            txCnt_q <= txCnt_q + DIV_W'(1);
          end else begin
            txCnt_q <= '0;
            case (txState_q)
              START: begin
                tx_q      <= txShift_q[0];
                txBit_q   <= '0;
                txState_q <= DATA;
              end
              DATA: begin
                if (txBit_q == LAST_BIT) begin
                  txStop2_q <= 1'b0;
                  if (parity_en) begin
                    tx_q      <= txPar_q;
                    txState_q <= PARITY;
                  end else begin
                    tx_q      <= 1'b1;
                    txState_q <= STOP;
                  end
                end else begin
                  txShift_q <= txShift_q >> 1;
                  tx_q      <= txShift_q[1];
                  txBit_q   <= txBit_q + BW'(1);
                end
              end
              PARITY: begin
                tx_q      <= 1'b1;
                txState_q <= STOP;
              end
              STOP: begin
                if (two_stop && !txStop2_q) txStop2_q <= 1'b1;
                else                        txState_q <= IDLE;
              end
              default: txState_q <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign tx      = tx_q;
  assign tx_full = txFull;
  assign tx_busy = (txState_q != IDLE) || !txEmpty;

  logic                 rxMeta_q, rxSync_q, rxPrev_q;
  logic [DATA_BITS-1:0] rxMem_q [FIFO_DEPTH];
  logic [AW:0]          rxWr_q, rxWr_d, rxRd_q, rxRd_d;
  logic                 rxEmpty, rxFull, rxPop, rxPush;

  state_e               rxState_q;
  logic [DIV_W-1:0]     rxCnt_q, rxHalf;
  logic [BW-1:0]        rxBit_q;
  logic [DATA_BITS-1:0] rxShift_q;
  logic                 rxPar_q, rxBreak_q;
  logic [2:0]           rxErr_q, errSet;
  logic                 rxTick, stopSample, frameOk;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= rx;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  assign rxEmpty    = (rxWr_q == rxRd_q);
  assign rxFull     = (rxWr_q[AW] != rxRd_q[AW]) && (rxWr_q[AW-1:0] == rxRd_q[AW-1:0]);
  assign rxPop      = rx_read && !rxEmpty;
  assign rxTick     = (rxCnt_q == baud_div);
  assign rxHalf     = baud_div >> 1;
  assign stopSample = (rxState_q == STOP) && !rxBreak_q && rxTick;
  assign frameOk    = stopSample && rxSync_q;
  assign rxPush     = frameOk && (!rxFull || rxPop);
  assign errSet     = {frameOk && !rxPush,
                       stopSample && !rxSync_q,
                       frameOk && parity_en && (rxPar_q != (^rxShift_q ^ parity_odd))};

  always_comb begin
    rxWr_d = rxWr_q + {{AW{1'b0}}, rxPush};
    rxRd_d = rxRd_q + {{AW{1'b0}}, rxPop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxWr_q  <= '0;
      rxRd_q  <= '0;
      rxErr_q <= '0;
    end else begin
      rxWr_q  <= rxWr_d;
      rxRd_q  <= rxRd_d;
      rxErr_q <= (rx_read ? 3'b000 : rxErr_q) | errSet;
    end
  end

  always_ff @(posedge clk) begin
    if (rxPush) rxMem_q[rxWr_q[AW-1:0]] <= rxShift_q;
  end

  // Counter starts at 1 on the detected edge so the start sample lands half a bit after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxState_q <= IDLE;
      rxCnt_q   <= '0;
      rxBit_q   <= '0;
      rxShift_q <= '0;
      rxPar_q   <= 1'b0;
      rxBreak_q <= 1'b0;
    end else begin
      case (rxState_q)
        IDLE: begin
          rxBreak_q <= 1'b0;
          rxCnt_q   <= '0;
          if (rxPrev_q && !rxSync_q) begin
            rxCnt_q   <= DIV_W'(1);
            rxState_q <= START;
          end
        end
        START: begin
          if (rxCnt_q >= rxHalf) begin
            rxCnt_q <= '0;
            rxBit_q <= '0;
            rxState_q <= rxSync_q ? IDLE : DATA;
          end else begin
            rxCnt_q <= rxCnt_q + DIV_W'(1);
          end
        end
        DATA: begin
          if (rxTick) begin
            rxCnt_q   <= '0;
            rxShift_q <= {rxSync_q, rxShift_q[DATA_BITS-1:1]};
            if (rxBit_q == LAST_BIT) rxState_q <= parity_en ? PARITY : STOP;
            else                     rxBit_q   <= rxBit_q + BW'(1);
          end else begin
            rxCnt_q <= rxCnt_q + DIV_W'(1);
          end
        end
        PARITY: begin
          if (rxTick) begin
            rxCnt_q   <= '0;
            rxPar_q   <= rxSync_q;
            rxState_q <= STOP;
          end else begin
            rxCnt_q <= rxCnt_q + DIV_W'(1);
          end
        end
        STOP: begin
          if (rxBreak_q) begin
            if (rxSync_q) rxState_q <= IDLE;
          end else if (rxTick) begin
            rxCnt_q <= '0;
            if (rxSync_q) rxState_q <= IDLE;
            else          rxBreak_q <= 1'b1;
          end else begin
            rxCnt_q <= rxCnt_q + DIV_W'(1);
          end
        end
        default: rxState_q <= IDLE;
      endcase
    end
  end

  assign rx_data  = rxEmpty ? '0 : rxMem_q[rxRd_q[AW-1:0]];
  assign rx_empty = rxEmpty;
  assign rx_err   = rxErr_q;
  assign rts      = !rxFull;

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: TX waveform table, loopback and injected
// RX frames against a queue-based reference, plus flow-control and reset corners.
module tb_uart_fifo;

  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 12;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [DIV_W-1:0]     baud_div = 12'd3;
  logic                 parity_en = 1'b0, parity_odd = 1'b0, two_stop = 1'b0;
  logic [DATA_BITS-1:0] tx_data = '0;
  logic                 tx_write = 1'b0;
  logic                 tx_full, tx_busy, tx;
  logic                 cts = 1'b1;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_read = 1'b0;
  logic                 rx_empty;
  logic [2:0]           rx_err;
  logic                 rts;

  logic loopEn = 1'b0;
  logic rxDrv  = 1'b1;
  assign rx = loopEn ? tx : rxDrv;

  int vecCount  = 0;
  int missCount = 0;

  logic [7:0] gotData[$];
  logic [2:0] gotErr[$];
  logic [7:0] expQ[$];

  typedef struct {
    logic [7:0]  data;
    logic        parEn;
    logic        parOdd;
    logic        twoStop;
    int          nBits;
    logic [11:0] expBits;
  } txVec_t;

  txVec_t vecs[5];

  always #5 clk = ~clk;

  uart_fifo #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .parity_en(parity_en),
    .parity_odd(parity_odd), .two_stop(two_stop), .tx_data(tx_data),
    .tx_write(tx_write), .tx_full(tx_full), .tx_busy(tx_busy), .tx(tx),
    .cts(cts), .rx(rx), .rx_data(rx_data), .rx_read(rx_read),
    .rx_empty(rx_empty), .rx_err(rx_err), .rts(rts)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic parOf(input logic [7:0] d, input logic odd);
    return ^d ^ odd;
  endfunction

  task automatic writeByte(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_write = 1'b1;
    @(negedge clk);
    tx_write = 1'b0;
  endtask

  task automatic pulseRead();
    @(negedge clk);
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
  endtask

  task automatic collect(input int nWant, input int budget);
    gotData.delete();
    gotErr.delete();
    for (int c = 0; c < budget && gotData.size() < nWant; c++) begin
      @(negedge clk);
      rx_read = 1'b0;
      if (!rx_empty) begin
        gotData.push_back(rx_data);
        gotErr.push_back(rx_err);
        rx_read = 1'b1;
      end
    end
    @(negedge clk);
    rx_read = 1'b0;
  endtask

  task automatic sendRxFrame(input logic [7:0] d, input logic parBit, input logic stopBit);
    int bl;
    bl = int'(baud_div) + 1;
    rxDrv = 1'b0;
    repeat (bl) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxDrv = d[i];
      repeat (bl) @(negedge clk);
    end
    if (parity_en) begin
      rxDrv = parBit;
      repeat (bl) @(negedge clk);
    end
    rxDrv = stopBit;
    repeat (bl) @(negedge clk);
    rxDrv = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic waitIdle(input string name);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!tx_busy) break;
    end
    checkOutput(name, tx_busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic checkQueue(input string name);
    checkOutput({name, "_count"}, gotData.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < gotData.size(); i++) begin
      checkOutput($sformatf("%s_data%0d", name, i), gotData[i], expQ[i]);
    end
  endtask

  // Serial waveform of one table entry at baud_div=3: every bit held exactly 4 cycles.
  task automatic applyStimulus(input txVec_t v);
    logic found;
    logic got;
    parity_en  = v.parEn;
    parity_odd = v.parOdd;
    two_stop   = v.twoStop;
    baud_div   = 12'd3;
    writeByte(v.data);
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput($sformatf("tx_start_%02h", v.data), found, 1);
    if (found) begin
      for (int i = 0; i < v.nBits; i++) begin
        got = v.expBits[i];
        for (int c = 0; c < 4; c++) begin
          if (i != 0 || c != 0) @(negedge clk);
          if (tx !== v.expBits[i]) got = tx;
        end
        checkOutput($sformatf("tx_%02h_bit%0d", v.data, i), got, v.expBits[i]);
      end
      @(negedge clk);
      checkOutput($sformatf("tx_%02h_busy_after", v.data), tx_busy, 0);
      checkOutput($sformatf("tx_%02h_idle_high", v.data), tx, 1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       corrupt, found;
    int         n;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 10, 12'h34A};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 11, 12'h478};
    vecs[2] = '{8'h01, 1'b1, 1'b1, 1'b1, 12, 12'hC02};
    vecs[3] = '{8'h80, 1'b1, 1'b0, 1'b1, 12, 12'hF00};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b0, 11, 12'h7FE};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_tx", tx, 1);
    checkOutput("rst_tx_full", tx_full, 0);
    checkOutput("rst_tx_busy", tx_busy, 0);
    checkOutput("rst_rx_empty", rx_empty, 1);
    checkOutput("rst_rx_err", rx_err, 0);
    checkOutput("rst_rts", rts, 1);
    checkOutput("rst_rx_data", rx_data, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] TX waveform table");
    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);
    repeat (5) @(negedge clk);

    $display("[TB] loopback odd parity, two stop bits");
    loopEn = 1'b1; parity_en = 1'b1; parity_odd = 1'b1; two_stop = 1'b1; baud_div = 12'd3;
    expQ = '{8'h00, 8'hFF, 8'h3C};
    foreach (expQ[i]) writeByte(expQ[i]);
    collect(3, 3 * 13 * 4 + 100);
    checkQueue("loop3");
    foreach (gotErr[i]) checkOutput($sformatf("loop3_err%0d", i), gotErr[i], 0);
    waitIdle("loop3_idle");

    $display("[TB] CTS hold and TX FIFO full");
    parity_en = 1'b0; two_stop = 1'b0; cts = 1'b0;
    expQ.delete();
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i * 8'h11);
      writeByte(d);
      if (expQ.size() < FIFO_DEPTH) expQ.push_back(d);
      if (i == 4) checkOutput("full_after4", tx_full, 1);
    end
    checkOutput("full_after5", tx_full, 1);
    repeat (20) @(negedge clk);
    checkOutput("cts_hold_tx", tx, 1);
    checkOutput("cts_hold_busy", tx_busy, 1);
    cts = 1'b1;
    collect(5, 5 * 45 + 100);
    checkQueue("cts4");
    waitIdle("cts4_idle");

    cts = 1'b0;
    expQ = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    for (int i = 0; i < 4; i++) writeByte(expQ[i]);
    checkOutput("full_again", tx_full, 1);
    @(negedge clk);
    tx_data = 8'hA5; tx_write = 1'b1; cts = 1'b1;
    @(negedge clk);
    tx_write = 1'b0;
    checkOutput("full_write_pop", tx_full, 1);
    collect(6, 6 * 45 + 100);
    checkQueue("wrpop");
    waitIdle("wrpop_idle");

    $display("[TB] RX frame error and glitch");
    loopEn = 1'b0; baud_div = 12'd7; parity_en = 1'b0;
    @(negedge clk);
    sendRxFrame(8'h55, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("ferr_empty", rx_empty, 1);
    checkOutput("ferr_err", rx_err, 3'b010);
    pulseRead();
    checkOutput("ferr_cleared", rx_err, 0);
    rxDrv = 1'b0;
    repeat (2) @(negedge clk);
    rxDrv = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("glitch_empty", rx_empty, 1);
    checkOutput("glitch_err", rx_err, 0);
    sendRxFrame(8'hC3, 1'b0, 1'b1);
    collect(1, 20);
    expQ = '{8'hC3};
    checkQueue("recover");

    $display("[TB] RX overrun");
    baud_div = 12'd3;
    expQ = '{8'h10, 8'h20, 8'h30, 8'h40};
    for (int i = 0; i < 5; i++) begin
      sendRxFrame(8'((i + 1) * 16), 1'b0, 1'b1);
      if (i == 3) begin
        checkOutput("ovr_rts_after4", rts, 0);
        checkOutput("ovr_err_after4", rx_err, 0);
      end
    end
    checkOutput("ovr_err", rx_err, 3'b100);
    checkOutput("ovr_rts", rts, 0);
    collect(4, 40);
    checkQueue("ovr");
    checkOutput("ovr_drained_empty", rx_empty, 1);
    checkOutput("ovr_drained_rts", rts, 1);
    checkOutput("ovr_err_cleared", rx_err, 0);

    $display("[TB] reset mid-frame");
    loopEn = 1'b1; cts = 1'b1;
    writeByte(8'hA5);
    writeByte(8'h5A);
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("rst_mid_start", found, 1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_tx", tx, 1);
    checkOutput("rst_mid_busy", tx_busy, 0);
    checkOutput("rst_mid_rx_empty", rx_empty, 1);
    rst = 1'b0;
    @(negedge clk);
    writeByte(8'h3C);
    collect(2, 200);
    expQ = '{8'h3C};
    checkQueue("post_rst");
    if (gotErr.size() > 0) checkOutput("post_rst_err", gotErr[0], 0);
    waitIdle("post_rst_idle");

    $display("[TB] random loopback batches");
    for (int it = 0; it < 6; it++) begin
      parity_en  = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      two_stop   = 1'($urandom_range(0, 1));
      baud_div   = 12'($urandom_range(2, 6));
      n = $urandom_range(1, FIFO_DEPTH);
      expQ.delete();
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        expQ.push_back(d);
        writeByte(d);
      end
      collect(n, n * (13 * (int'(baud_div) + 1) + 2) + 100);
      checkQueue($sformatf("rloop%0d", it));
      foreach (gotErr[i]) checkOutput($sformatf("rloop%0d_err%0d", it, i), gotErr[i], 0);
      waitIdle($sformatf("rloop%0d_idle", it));
    end

    $display("[TB] random injected RX frames");
    loopEn = 1'b0;
    for (int it = 0; it < 8; it++) begin
      parity_en  = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      two_stop   = 1'b0;
      baud_div   = 12'($urandom_range(3, 7));
      d = 8'($urandom);
      corrupt = parity_en & 1'($urandom_range(0, 1));
      repeat (3) @(negedge clk);
      sendRxFrame(d, parOf(d, parity_odd) ^ corrupt, 1'b1);
      collect(1, 20);
      expQ = '{d};
      checkQueue($sformatf("rinj%0d", it));
      if (gotErr.size() > 0) checkOutput($sformatf("rinj%0d_err", it), gotErr[0], {2'b00, corrupt});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
